// File: rtl/p2s_frame_sequencer.sv
// Control sequencer for the two-nibble parallel-to-serial path: nibble handshake, load strobes, mux bit-select stepping.
// Optional P2S_PARITY_EN appends an even-parity slot after the data bits (adds ser_in / par_slot ports).
module p2s_frame_sequencer #(
  parameter int DATA_W    = 8,
  parameter int SEL_W     = 3,
  parameter int MSB_FIRST = 1,
  parameter int GAP_CYC   = 2
) (
  input  logic             ck,
  input  logic             reset,
  input  logic             start,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             LD1,
  output logic             LD2,
  output logic [SEL_W-1:0] sel,
  output logic             VO,
  output logic             OK,
  output logic             busy
`ifdef P2S_PARITY_EN
  ,
  input  logic             ser_in,
  output logic             par_slot
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_HI, S_LOAD_LO, S_SHIFT, S_PARITY, S_GAP
  } state_e;

  localparam logic [SEL_W-1:0] SEL_FIRST = (MSB_FIRST != 0) ? SEL_W'(DATA_W-1) : '0;
  localparam logic [SEL_W-1:0] SEL_LAST  = (MSB_FIRST != 0) ? '0 : SEL_W'(DATA_W-1);
  localparam int               GW        = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0]    GAP_LAST  = GW'((GAP_CYC > 0) ? GAP_CYC-1 : 0);
  localparam state_e           POST_FRAME = (GAP_CYC == 0) ? S_IDLE : S_GAP;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             vo_q, vo_d, ok_q, ok_d, busy_q, busy_d;
`ifdef P2S_PARITY_EN
  logic             par_q, par_d;
  logic             par_slot_q, par_slot_d;
`endif

  // Handshake strobes decode straight from the current state so the nibble lands on the transfer edge.
  assign din_ready = (state_q == S_LOAD_HI) || (state_q == S_LOAD_LO);
  assign LD1       = din_valid && (state_q == S_LOAD_HI);
  assign LD2       = din_valid && (state_q == S_LOAD_LO);
  assign sel       = sel_q;
  assign VO        = vo_q;
  assign OK        = ok_q;
  assign busy      = busy_q;
`ifdef P2S_PARITY_EN
  assign par_slot  = par_slot_q;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gap_d   = gap_q;
`ifdef P2S_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE:    if (start) state_d = S_LOAD_HI;
      S_LOAD_HI: if (din_valid) state_d = S_LOAD_LO;
      S_LOAD_LO: if (din_valid) begin
        state_d = S_SHIFT;
        sel_d   = SEL_FIRST;
`ifdef P2S_PARITY_EN
        par_d   = 1'b0;
`endif
      end
      S_SHIFT: begin
`ifdef P2S_PARITY_EN
        par_d = par_q ^ ser_in;
`endif
        if (sel_q == SEL_LAST) begin
`ifdef P2S_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = POST_FRAME;
`endif
          gap_d = '0;
        end else if (MSB_FIRST != 0) begin
          sel_d = sel_q - 1'b1;
        end else begin
          sel_d = sel_q + 1'b1;
        end
      end
      S_PARITY: begin
        state_d = POST_FRAME;
        gap_d   = '0;
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Registered outputs are computed from the next state so they line up with it.
    busy_d = (state_d != S_IDLE);
    vo_d   = (state_d == S_SHIFT) || (state_d == S_PARITY);
`ifdef P2S_PARITY_EN
    ok_d       = (state_d == S_PARITY);
    par_slot_d = (state_d == S_PARITY);
`else
    ok_d   = (state_d == S_SHIFT) && (sel_d == SEL_LAST);
`endif
  end

  always_ff @(posedge ck) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      gap_q   <= '0;
      vo_q    <= 1'b0;
      ok_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef P2S_PARITY_EN
      par_q      <= 1'b0;
      par_slot_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gap_q   <= gap_d;
      vo_q    <= vo_d;
      ok_q    <= ok_d;
      busy_q  <= busy_d;
`ifdef P2S_PARITY_EN
      par_q      <= par_d;
      par_slot_q <= par_slot_d;
`endif
    end
  end

endmodule

// File: tb/tb_p2s_frame_sequencer.sv
// Bench for p2s_frame_sequencer: vector table, directed corner sequences and random traffic against a frame-level model.
module tb_p2s_frame_sequencer;
  localparam int DATA_W = 8, SEL_W = 3, MSB_FIRST = 1, GAP_CYC = 2;
`ifdef P2S_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic ck = 1'b0;
  logic reset = 1'b0, start = 1'b0, din_valid = 1'b0;
  logic [3:0] din = '0;
  logic din_ready, LD1, LD2, VO, OK, busy;
  logic [SEL_W-1:0] sel;
  logic [3:0] r1 = '0, r2 = '0;
  logic [7:0] dp_bus;
  logic mux_out;
`ifdef P2S_PARITY_EN
  logic ser_in, par_slot;
  assign ser_in = mux_out;
`endif

  always #5 ck = ~ck;

  // Minimal serializer datapath: nibble registers plus 8:1 mux.
  always @(posedge ck) begin
    if (LD1) r1 <= din;
    if (LD2) r2 <= din;
  end
  assign dp_bus  = {r1, r2};
  assign mux_out = dp_bus[sel];

  p2s_frame_sequencer #(.DATA_W(DATA_W), .SEL_W(SEL_W), .MSB_FIRST(MSB_FIRST), .GAP_CYC(GAP_CYC)) dut (
    .ck(ck), .reset(reset), .start(start), .din_valid(din_valid), .din_ready(din_ready),
    .LD1(LD1), .LD2(LD2), .sel(sel), .VO(VO), .OK(OK), .busy(busy)
`ifdef P2S_PARITY_EN
    , .ser_in(ser_in), .par_slot(par_slot)
`endif
  );

  int checks = 0, failures = 0, cyc_n = 0;
  int ok_cnt = 0, vo_cnt = 0, ld1_cnt = 0, ld2_cnt = 0, ps_cnt = 0;
  int ok_cyc = 0, gap_meas = -1;
  bit wait_rise = 0, prev_rdy = 0;

  // Frame-level model: phase 0 idle, 1 want high nibble, 2 want low nibble, 3 data bits, 4 parity, 5 gap.
  int m_phase = 0, m_bits = 0, m_gap = 0;
  bit m_known = 0;
  logic [7:0] m_frame = '0;
  logic [SEL_W-1:0] m_hold = '0;

  function automatic logic [SEL_W-1:0] idx(input int b);
    return (MSB_FIRST != 0) ? SEL_W'(DATA_W-1-b) : SEL_W'(b);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc_n, act, exp);
    end
  endtask

  task automatic step(input bit rst, input bit st, input bit dv, input logic [3:0] d);
    logic [SEL_W-1:0] e_sel;
    @(negedge ck);
    reset = rst; start = st; din_valid = dv; din = d;
    #1;
    if (m_known) begin
      e_sel = (m_phase == 3) ? idx(m_bits) : m_hold;
      chk("busy", busy, m_phase != 0);
      chk("din_ready", din_ready, m_phase == 1 || m_phase == 2);
      chk("LD1", LD1, m_phase == 1 && dv);
      chk("LD2", LD2, m_phase == 2 && dv);
      chk("VO", VO, m_phase == 3 || m_phase == 4);
      chk("OK", OK, (m_phase == 3 && m_bits == DATA_W-1 && !PAR) || m_phase == 4);
      chk("sel", sel, e_sel);
      if (m_phase == 3) chk("ser_bit", mux_out, m_frame[e_sel]);
`ifdef P2S_PARITY_EN
      chk("par_slot", par_slot, m_phase == 4);
      if (m_phase == 4) chk("parity", dut.par_q, ^m_frame);
`endif
    end
    if (OK === 1'b1) begin ok_cnt++; ok_cyc = cyc_n; wait_rise = 1; end
    if (VO === 1'b1) vo_cnt++;
    if (LD1 === 1'b1) ld1_cnt++;
    if (LD2 === 1'b1) ld2_cnt++;
`ifdef P2S_PARITY_EN
    if (par_slot === 1'b1) ps_cnt++;
`endif
    if (wait_rise && din_ready === 1'b1 && !prev_rdy) begin gap_meas = cyc_n - ok_cyc; wait_rise = 0; end
    prev_rdy = (din_ready === 1'b1);
    // Advance the model across the coming rising edge.
    if (!rst) begin
      m_phase = 0; m_hold = '0; m_known = 1;
    end else begin
      case (m_phase)
        0: if (st) m_phase = 1;
        1: if (dv) begin m_frame[7:4] = d; m_phase = 2; end
        2: if (dv) begin m_frame[3:0] = d; m_phase = 3; m_bits = 0; end
        3: begin
          m_hold = idx(m_bits);
          if (m_bits == DATA_W-1) begin
            m_phase = PAR ? 4 : (GAP_CYC == 0 ? 0 : 5);
            m_gap = GAP_CYC;
          end else m_bits++;
        end
        4: begin m_phase = (GAP_CYC == 0) ? 0 : 5; m_gap = GAP_CYC; end
        default: begin m_gap--; if (m_gap == 0) m_phase = 0; end
      endcase
    end
    cyc_n++;
  endtask

  task automatic clr_counts();
    ok_cnt = 0; vo_cnt = 0; ld1_cnt = 0; ld2_cnt = 0; ps_cnt = 0;
  endtask

  typedef struct {
    bit rst, st, dv; logic [3:0] d;
    bit busy, rdy, ld1, ld2, vo, ok; logic [SEL_W-1:0] sel; bit chkbit, sbit;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit rst, st, dv, input logic [3:0] d, input bit b, r, l1, l2, v, o,
                     input logic [SEL_W-1:0] s, input bit cb, sb);
    vec_t t;
    t.rst = rst; t.st = st; t.dv = dv; t.d = d; t.busy = b; t.rdy = r; t.ld1 = l1; t.ld2 = l2;
    t.vo = v; t.ok = o; t.sel = s; t.chkbit = cb; t.sbit = sb;
    tbl.push_back(t);
  endtask

  initial begin
    logic [7:0] pat;
    pat = 8'hA5;
    // Reset held with start/din_valid high, then a nominal A/5 frame.
    add(0,1,1,4'h0, 0,0,0,0,0,0, 3'd0, 0,0);
    add(0,1,1,4'h0, 0,0,0,0,0,0, 3'd0, 0,0);
    add(1,1,0,4'h0, 0,0,0,0,0,0, 3'd0, 0,0);
    add(1,0,1,4'hA, 1,1,1,0,0,0, 3'd0, 0,0);
    add(1,0,1,4'h5, 1,1,0,1,0,0, 3'd0, 0,0);
    for (int i = 0; i < 8; i++)
      add(1,0,0,4'h0, 1,0,0,0,1, (i == 7) && !PAR, 3'(7-i), 1, pat[7-i]);
    if (PAR) add(1,0,0,4'h0, 1,0,0,0,1,1, 3'd0, 0,0);
    add(1,0,0,4'h0, 1,0,0,0,0,0, 3'd0, 0,0);
    add(1,0,0,4'h0, 1,0,0,0,0,0, 3'd0, 0,0);
    add(1,0,0,4'h0, 0,0,0,0,0,0, 3'd0, 0,0);

    step(0, 0, 0, 4'h0);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].st, tbl[i].dv, tbl[i].d);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("tbl%0d_rdy", i), din_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_ld", i), {LD1, LD2}, {tbl[i].ld1, tbl[i].ld2});
      chk($sformatf("tbl%0d_vo_ok", i), {VO, OK}, {tbl[i].vo, tbl[i].ok});
      chk($sformatf("tbl%0d_sel", i), sel, tbl[i].sel);
      if (tbl[i].chkbit) chk($sformatf("tbl%0d_bit", i), mux_out, tbl[i].sbit);
    end

    // Stalled source.
    clr_counts();
    step(1, 1, 0, 4'h0);
    repeat (3) begin step(1, 0, 0, 4'h9); chk("stall_hi_vo", VO, 0); end
    step(1, 0, 1, 4'h3);
    repeat (2) begin step(1, 0, 0, 4'hF); chk("stall_lo_vo", VO, 0); end
    step(1, 0, 1, 4'hC);
    repeat (DATA_W + PAR + GAP_CYC + 2) step(1, 0, 0, 4'h0);
    chk("stall_ld1_cnt", ld1_cnt, 1);
    chk("stall_ld2_cnt", ld2_cnt, 1);
    chk("stall_vo_cnt", vo_cnt, DATA_W + PAR);
    chk("stall_ok_cnt", ok_cnt, 1);

    // Start held high through SHIFT and GAP.
    clr_counts(); gap_meas = -1; wait_rise = 0;
    repeat (30) step(1, 1, 1, 4'($urandom_range(0, 15)));
    chk("restart_gap", gap_meas, GAP_CYC + 2);
    chk("held_start_frames", ok_cnt, 2);
    repeat (20) step(1, 0, 0, 4'h0);

    // Abort at the 4th shift cycle, then a fresh full frame.
    clr_counts();
    step(1, 1, 0, 4'h0); step(1, 0, 1, 4'h6); step(1, 0, 1, 4'hB);
    repeat (3) step(1, 0, 0, 4'h0);
    step(0, 0, 0, 4'h0);
    repeat (4) step(1, 0, 0, 4'h0);
    chk("abort_idle", busy, 0);
    chk("abort_no_ok", ok_cnt, 0);
    clr_counts();
    // Frame 8'hA7: even-parity bit is 1 when the parity slot is built in.
    step(1, 1, 0, 4'h0); step(1, 0, 1, 4'hA); step(1, 0, 1, 4'h7);
    repeat (DATA_W + PAR + GAP_CYC + 2) step(1, 0, 0, 4'h0);
    chk("a7_vo_cnt", vo_cnt, DATA_W + PAR);
    chk("a7_ok_cnt", ok_cnt, 1);
    chk("a7_par_slots", ps_cnt, PAR ? 1 : 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           4'($urandom_range(0, 15)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
